// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: sample-beat bus carrying (op, a, b, y) over valid/ready.
// The master drives the beat; the slave (the checker) returns in_ready.
interface gate_response_checker_if #(
    parameter int unsigned WIDTH = 4
) ();

    localparam int unsigned OP_W = 2;

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [WIDTH-1:0]  in_y;

    // Producer side: stimulus source or DUT output tap
    modport master (
        output in_valid,
        output in_last,
        output op,
        output in_a,
        output in_b,
        output in_y,
        input  in_ready
    );

    // Consumer side: the checker
    modport slave (
        input  in_valid,
        input  in_last,
        input  op,
        input  in_a,
        input  in_b,
        input  in_y,
        output in_ready
    );

endinterface

// File: rtl/gate_response_checker.sv
// gate_response_checker: checks a stream of (a, b, y) beats against a bitwise
// gate function of a and b, keeps saturating total/fail counters, pulses a
// registered mismatch per failing beat and holds a pass/fail verdict at stream end.
// Optional macro GATE_CHK_CAPTURE_EN adds first-failing-beat capture ports.
module gate_response_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    gate_response_checker_if.slave   in_if,
    output logic                     mismatch,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     done,
    output logic                     pass
`ifdef GATE_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]         first_fail_a,
    output logic [WIDTH-1:0]         first_fail_b,
    output logic [WIDTH-1:0]         first_fail_y
`endif
);

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_W-1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic               mismatch_q, mismatch_d;
    logic [CNT_W-1:0]   total_q,    total_d;
    logic [CNT_W-1:0]   fail_q,     fail_d;
    logic               done_q,     done_d;
    logic               pass_q,     pass_d;

`ifdef GATE_CHK_CAPTURE_EN
    logic               ff_valid_q, ff_valid_d;
    logic [WIDTH-1:0]   ff_a_q,     ff_a_d;
    logic [WIDTH-1:0]   ff_b_q,     ff_b_d;
    logic [WIDTH-1:0]   ff_y_q,     ff_y_d;
`endif

    logic               in_ready_c;
    logic               accept_c;
    logic [WIDTH-1:0]   exp_c;
    logic               beat_fail_c;
    logic [CNT_W-1:0]   total_inc_c;
    logic [CNT_W-1:0]   fail_inc_c;

    // Ready only while running; start pre-empts any beat in the same cycle
    assign in_ready_c     = (state_q == S_RUN) && !start;
    assign in_if.in_ready = in_ready_c;
    assign accept_c       = in_if.in_valid && in_ready_c;

    // Expected result for the selected gate function
    always_comb begin
        exp_c = '0;
        case (in_if.op)
            OP_AND:  exp_c = in_if.in_a & in_if.in_b;
            OP_OR:   exp_c = in_if.in_a | in_if.in_b;
            OP_XOR:  exp_c = in_if.in_a ^ in_if.in_b;
            OP_NAND: exp_c = ~(in_if.in_a & in_if.in_b);
            default: exp_c = '0;
        endcase
    end

    // Case inequality so X/Z on the observed result is reported as a failure in simulation
    assign beat_fail_c = (in_if.in_y !== exp_c);

    // Saturating increments: counters stick at all-ones instead of wrapping
    assign total_inc_c = (total_q == '1) ? total_q : total_q + CNT_W'(1);
    assign fail_inc_c  = (fail_q  == '1) ? fail_q  : fail_q  + CNT_W'(1);

    // Next-state and next-output logic for the run controller and counters
    always_comb begin
        state_d    = state_q;
        mismatch_d = 1'b0;
        total_d    = total_q;
        fail_d     = fail_q;
        done_d     = done_q;
        pass_d     = pass_q;
`ifdef GATE_CHK_CAPTURE_EN
        ff_valid_d = ff_valid_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_y_d     = ff_y_q;
`endif

        if (start) begin
            // Restart from any state, discarding counts, verdict and capture
            state_d = S_RUN;
            total_d = '0;
            fail_d  = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
`ifdef GATE_CHK_CAPTURE_EN
            ff_valid_d = 1'b0;
            ff_a_d     = '0;
            ff_b_d     = '0;
            ff_y_d     = '0;
`endif
        end else if (accept_c) begin
            total_d    = total_inc_c;
            mismatch_d = beat_fail_c;
            if (beat_fail_c) begin
                fail_d = fail_inc_c;
            end
`ifdef GATE_CHK_CAPTURE_EN
            if (beat_fail_c && !ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_a_d     = in_if.in_a;
                ff_b_d     = in_if.in_b;
                ff_y_d     = in_if.in_y;
            end
`endif
            // Last beat closes the run; its result is part of the verdict
            if (in_if.in_last) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = (fail_d == '0) && (total_d != '0);
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mismatch_q <= 1'b0;
            total_q    <= '0;
            fail_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            total_q    <= total_d;
            fail_q     <= fail_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

`ifdef GATE_CHK_CAPTURE_EN
    // First-failure capture registers, loaded once per run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_y_q     <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_y_q     <= ff_y_d;
        end
    end

    assign first_fail_a = ff_a_q;
    assign first_fail_b = ff_b_q;
    assign first_fail_y = ff_y_q;
`endif

    assign mismatch  = mismatch_q;
    assign total_cnt = total_q;
    assign fail_cnt  = fail_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Receive-side companion to the gate-level stimulus benches. It accepts a stream of (a, b, y) samples over a valid/ready handshake and checks each observed result y against the expected bitwise function of a and b. It keeps saturating pass/fail counters and a registered per-sample mismatch pulse, and reports a final verdict when the stream ends. It sits between a DUT's output and the bench or on-chip self-test controller, so vector runs are judged in hardware rather than by reading `$monitor` logs.

## Interface
- `WIDTH`, default 4: operand and result width in bits.
- `CNT_W`, default 16: width of the sample, pass and fail counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `op` input 2: expected function. 00 AND, 01 OR, 10 XOR, 11 NAND. Sampled with each accepted beat.
- `start` input 1: one-cycle pulse. Clears all counters and verdict, then enters RUN.
- `in_valid` input 1: a sample beat is present.
- `in_ready` output 1: the checker can accept a beat.
- `in_last` input 1: marks the final beat of a run.
- `in_a` input WIDTH: operand a.
- `in_b` input WIDTH: operand b.
- `in_y` input WIDTH: observed DUT output.
- `mismatch` output 1: one-cycle pulse, registered, indicating the previous accepted beat failed.
- `total_cnt` output CNT_W: number of beats accepted.
- `fail_cnt` output CNT_W: number of failing beats.
- `done` output 1: high while in DONE.
- `pass` output 1: valid while `done` is high. Equals (`fail_cnt` == 0) && (`total_cnt` != 0).
- `first_fail_a`, `first_fail_b`, `first_fail_y` output WIDTH each: first failing beat. Present only with `GATE_CHK_CAPTURE_EN`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: accepting beats.
  - DONE: verdict held.
- Transitions:
  - IDLE to RUN on `start`.
  - RUN to DONE on an accepted beat with `in_last`=1.
  - RUN to RUN on `start`: restart, all counters cleared.
  - DONE to RUN on `start`.
  - No other exits.
- `in_ready` = (state == RUN) && !`start`. This is combinational from state and `start`. `start` always wins over a simultaneous beat, and that beat is not accepted.
- A beat is accepted when `in_valid` && `in_ready` on a rising edge.
- Expected value: exp = f(op, in_a, in_b), computed bitwise over WIDTH bits. NAND is ~(a & b).
- A beat fails if `in_y` != exp on any bit. X/Z on `in_y` counts as a failure in simulation; the comparison uses case-inequality semantics in the model.
- Counter updates per accepted beat:
  - `total_cnt` increments.
  - `fail_cnt` increments on failure.
  - Both saturate at 2^CNT_W−1; they never wrap.
- Beats presented in IDLE or DONE are ignored: `in_ready` is 0 and nothing changes.
- `pass` is 0 whenever `done` is 0.

## Timing
- Reset values (asynchronous, taking effect immediately when `rst_n` goes low):
  - state = IDLE.
  - `in_ready`, `mismatch`, `done` and `pass` = 0.
  - All counters = 0.
  - Capture registers = 0.
- Reset asserted mid-RUN aborts the run. No verdict is produced.
- Accepted beat at edge N:
  - `total_cnt` and `fail_cnt` show the updated values after edge N.
  - `mismatch` is high for exactly the cycle after edge N, and only if that beat failed.
- Last beat accepted at edge N: `done` and `pass` are valid after edge N. The last beat is included in the counts and the verdict.
- `start` at edge N: counters, verdict and capture are cleared, and state is RUN, after edge N. The earliest acceptable beat is at edge N+1.
- Throughput is one beat per clock. There are no bubbles.

## Configuration
- `GATE_CHK_CAPTURE_EN` defined:
  - Adds a sticky `first_fail_valid` internal flag and the `first_fail_a`, `first_fail_b` and `first_fail_y` output ports.
  - Loads them on the first failing beat after `start` or reset. They are updated after the same edge as `fail_cnt`.
  - Later failures do not overwrite them.
  - They are cleared by `start`.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

## Test plan
- Clean NAND run: reset, `start`, `op`=11. Send beats (0000,0000,1111), (1010,0101,1111), (1111,1111,0000), (1100,0110,1011 with last). Required: `total_cnt`=4, `fail_cnt`=0, `done`=1, `pass`=1, `mismatch` never asserted.
- Injected fault: same run but the third beat has y=0001. Required:
  - `mismatch` is high only in the cycle after that beat.
  - `fail_cnt`=1 and `pass`=0.
  - With capture enabled, the first_fail outputs = 1111/1111/0001.
- Op coverage: with a=1100 and b=1010, the correct y for AND/OR/XOR/NAND (1000/1110/0110/0111) passes. The y for a neighbouring op fails, giving `fail_cnt`=1 per wrong beat.
- Handshake: `in_valid` held high in IDLE and in DONE. Required: `in_ready`=0 and counters unchanged.
- Start with a beat: `start` coincides with `in_valid`. Required: that beat is not counted. `start` issued mid-RUN clears `total_cnt` to 0.
- Reset and saturation:
  - `rst_n` dropped mid-run: all outputs 0 immediately, state IDLE.
  - With CNT_W=3, 9 failing beats: `fail_cnt` and `total_cnt` hold at 7.
